// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell reused LSB-first over
// WIDTH-bit operands, with valid/ready handshakes on both sides.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_r;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_en;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_r_next;
  logic             w_accept;
  logic             w_last;

  // r_en keeps in_ready low until the first edge after reset is released.
  assign in_ready  = r_en && (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  assign w_s      = r_sa[0] ^ r_sb[0] ^ r_c;
  assign w_co     = (r_sa[0] & r_sb[0]) | (r_sb[0] & r_c) | (r_sa[0] & r_c);
  assign w_r_next = {w_s, r_r[WIDTH-1:1]};
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_en    <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_r    <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Subtract is A + ~B + 1: the +1 enters as the initial carry.
            r_sa  <= a;
            r_sb  <= sub ? ~b : b;
            r_c   <= sub;
            r_r   <= '0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_r   <= w_r_next;
          r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
          r_c   <= w_co;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum  <= w_r_next;
            r_cout <= w_co;
            r_ovf  <= r_c ^ w_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed vectors, backpressure,
// asynchronous mid-run reset and back-to-back random traffic with a scoreboard.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [W+1:0] exp_q[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: {sum, cout, ovf}; overflow from operand/result sign rules.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    logic [W:0]   full;
    logic [W-1:0] yy;
    logic         o;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
    if (!s) o = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    else    o = (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]);
    return {full[W-1:0], full[W], o};
  endfunction

  // Drives one operation, pushes its expectation, returns the acceptance cycle.
  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s,
                      input logic [W+1:0] expv, output int acc, output bit to);
    to = 1'b0;
    acc = 0;
    a = aa; b = bb; sub = s; in_valid = 1'b1;
    exp_q.push_back(expv);
    for (int k = 0; k < 50 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) begin
      to = 1'b1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit to);
    to = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (out_valid) begin
        to = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    #12;
    n_checks++;
    if ({sum, cout, ovf, out_valid, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b ov=%b ir=%b, need all 0",
               sum, cout, ovf, out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b need 0", in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_edge: got %b need 1", in_ready);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] va[4] = '{8'h5A, 8'h10, 8'h80, 8'hFF};
    logic [W-1:0] vb[4] = '{8'h33, 8'h20, 8'h01, 8'h01};
    logic         vs[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [W+1:0] ve[4] = '{{8'h8D, 1'b0, 1'b1}, {8'hF0, 1'b0, 1'b0},
                           {8'h7F, 1'b1, 1'b1}, {8'h00, 1'b1, 1'b0}};
    int acc;
    bit to;
    logic [W+1:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(va[i], vb[i], vs[i], ve[i], acc, to);
      if (!to) wait_out(to);
      n_checks++;
      if (to) begin
        n_fail++;
        $display("FAIL directed_timeout[%0d]: no handshake within bound", i);
        exp_q.delete();
        continue;
      end
      n_checks++;
      if (cyc - acc != W) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d need %0d", i, cyc - acc, W);
      end
      e = exp_q.pop_front();
      n_checks++;
      if ({sum, cout, ovf} !== e) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got sum=%h cout=%b ovf=%b need sum=%h cout=%b ovf=%b",
                 i, sum, cout, ovf, e[W+1:2], e[1], e[0]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || {sum, cout, ovf} !== e) begin
        n_fail++;
        $display("FAIL directed_release[%0d]: got ov=%b ir=%b sum=%h need ov=0 ir=1 sum=%h",
                 i, out_valid, in_ready, sum, e[W+1:2]);
      end
    end
  endtask

  task automatic test_backpressure;
    int acc;
    bit to;
    logic [W+1:0] e1;
    logic [W+1:0] e2;
    e1 = model(8'h3C, 8'h4B, 1'b0);
    e2 = model(8'h21, 8'h9E, 1'b1);
    out_ready = 1'b0;
    send(8'h3C, 8'h4B, 1'b0, e1, acc, to);
    if (!to) wait_out(to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL bp_timeout: no first result");
      out_ready = 1'b1;
      exp_q.delete();
      return;
    end
    a = 8'h21; b = 8'h9E; sub = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({sum, cout, ovf} !== e1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got sum=%h cout=%b ovf=%b ir=%b ov=%b need sum=%h cout=%b ovf=%b ir=0 ov=1",
                 k, sum, cout, ovf, in_ready, out_valid, e1[W+1:2], e1[1], e1[0]);
      end
    end
    void'(exp_q.pop_front());
    exp_q.push_back(e2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_idle: got ir=%b ov=%b need ir=1 ov=0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc = cyc;
    wait_out(to);
    n_checks++;
    if (to || cyc - acc != W) begin
      n_fail++;
      $display("FAIL bp_second_latency: got %0d (timeout=%b) need %0d", cyc - acc, to, W);
    end
    e2 = exp_q.pop_front();
    n_checks++;
    if ({sum, cout, ovf} !== e2) begin
      n_fail++;
      $display("FAIL bp_second_result: got sum=%h cout=%b ovf=%b need sum=%h cout=%b ovf=%b",
               sum, cout, ovf, e2[W+1:2], e2[1], e2[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun;
    int acc;
    bit to;
    int seen;
    out_ready = 1'b1;
    send(8'h5A, 8'h33, 1'b0, model(8'h5A, 8'h33, 1'b0), acc, to);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    n_checks++;
    if ({sum, cout, ovf, out_valid, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset_outputs: got sum=%h cout=%b ovf=%b ov=%b ir=%b need all 0 (timeout=%b)",
               sum, cout, ovf, out_valid, in_ready, to);
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_during_reset: got ir=%b ov=%b need 0 0", in_ready, out_valid);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_ready_pre_edge: got %b need 0", in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_ready_post_edge: got %b need 1", in_ready);
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midrun_spurious_valid: got %0d valid cycles need 0", seen);
    end
    send(8'h01, 8'h01, 1'b0, {8'h02, 1'b0, 1'b0}, acc, to);
    if (!to) wait_out(to);
    n_checks++;
    if (to || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL recover_timeout: got no result need sum=02");
      exp_q.delete();
    end else begin
      logic [W+1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if ({sum, cout, ovf} !== e) begin
        n_fail++;
        $display("FAIL recover_result: got sum=%h cout=%b ovf=%b need sum=%h cout=%b ovf=%b",
                 sum, cout, ovf, e[W+1:2], e[1], e[0]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    localparam int N = 1000;
    int got;
    out_ready = 1'b1;
    got = 0;
    fork
      begin : drv
        int prev;
        for (int i = 0; i < N; i++) begin
          logic [W-1:0] xa;
          logic [W-1:0] xb;
          logic         xs;
          xa = W'($urandom);
          xb = W'($urandom);
          xs = 1'($urandom_range(0, 1));
          a = xa; b = xb; sub = xs; in_valid = 1'b1;
          for (int k = 0; k < 30 && !in_ready; k++) begin
            @(posedge clk); #1;
          end
          if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL b2b_accept_timeout[%0d]: in_ready never rose", i);
            break;
          end
          exp_q.push_back(model(xa, xb, xs));
          @(posedge clk); #1;
          if (i > 0) begin
            n_checks++;
            if (cyc - prev != W + 2) begin
              n_fail++;
              $display("FAIL b2b_spacing[%0d]: got %0d need %0d", i, cyc - prev, W + 2);
            end
          end
          prev = cyc;
        end
        in_valid = 1'b0;
      end
      begin : mon
        for (int k = 0; k < N * (W + 2) + 100 && got < N; k++) begin
          @(posedge clk); #1;
          if (out_valid) begin
            logic [W+1:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL b2b_unexpected: got sum=%h need no result", sum);
            end else begin
              e = exp_q.pop_front();
              if ({sum, cout, ovf} !== e) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: got sum=%h cout=%b ovf=%b need sum=%h cout=%b ovf=%b",
                         got, sum, cout, ovf, e[W+1:2], e[1], e[0]);
              end
            end
            got++;
          end
        end
      end
    join
    n_checks++;
    if (got != N) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results need %0d", got, N);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
